// File: rtl/input_conditioner_pkg.sv
// Shared channel state encoding and timing constants for the button input front end.
// DEF_* values target a 50 MHz clock; SIM_* values shrink timing for simulation.
package input_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_RELEASE_DB = 3'd4
  } chan_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_DAS_DELAY       = 8333333;
  localparam int DEF_DAS_REPEAT      = 2500000;
  localparam int DEF_CNT_W           = 24;

  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_DAS_DELAY       = 10;
  localparam int SIM_DAS_REPEAT      = 3;
  localparam int SIM_CNT_W           = 8;

  // A channel counts as engaged from accepted press until its release is confirmed.
  function automatic logic is_engaged(chan_state_t s);
    return (s == ST_HELD) || (s == ST_REPEAT) || (s == ST_RELEASE_DB);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw button levels, acks and conditioned command outputs between board pins and game control.
interface input_conditioner_if;
  logic raw_left;
  logic raw_right;
  logic raw_rotate;
  logic raw_go;
  logic left_ack;
  logic right_ack;
  logic rotate_ack;
  logic left;
  logic right;
  logic rotate;
  logic go;

  modport master (
    output raw_left, raw_right, raw_rotate, raw_go,
    output left_ack, right_ack, rotate_ack,
    input  left, right, rotate, go
  );

  modport slave (
    input  raw_left, raw_right, raw_rotate, raw_go,
    input  left_ack, right_ack, rotate_ack,
    output left, right, rotate, go
  );
endinterface

// File: rtl/input_conditioner_button_channel.sv
// One button: 2-flop synchroniser, debounce FSM with saturating counter and optional auto-repeat.
// tick is a single-cycle pulse issued on the edge that accepts a press or repeat.
module button_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DAS_DELAY       = DEF_DAS_DELAY,
  parameter int DAS_REPEAT      = DEF_DAS_REPEAT,
  parameter int CNT_W           = DEF_CNT_W,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        raw,
  output logic        tick,
  output chan_state_t state
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(DAS_REPEAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             sync_meta;
  logic             sync_lvl;
  chan_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             from_repeat;
  logic             from_repeat_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_lvl  <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      from_repeat <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      from_repeat <= from_repeat_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    tick            = 1'b0;
    from_repeat_nxt = from_repeat;
    case (state)
      ST_IDLE: begin
        if (sync_lvl) state_nxt = ST_PRESS_DB;
      end
      ST_PRESS_DB: begin
        if (!sync_lvl) begin
          state_nxt = ST_IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_HELD;
          tick      = 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync_lvl) begin
          state_nxt       = ST_RELEASE_DB;
          from_repeat_nxt = 1'b0;
        end else if (REPEAT_EN && (cnt == DAS_LAST)) begin
          state_nxt = ST_REPEAT;
          tick      = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!sync_lvl) begin
          state_nxt       = ST_RELEASE_DB;
          from_repeat_nxt = 1'b1;
        end else if (cnt == REP_LAST) begin
          tick = 1'b1;
        end
      end
      ST_RELEASE_DB: begin
        // A bounce during release returns to wherever the hold was, keeping repeat cadence mode.
        if (sync_lvl) begin
          state_nxt = from_repeat ? ST_REPEAT : ST_HELD;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if ((state_nxt != state) || tick || (state == ST_IDLE)) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Four debounced button channels feeding sticky left/right/rotate request flags and a go level.
// Flags set on channel ticks, clear on ack; simultaneous left+right hold blanks both.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DAS_DELAY       = DEF_DAS_DELAY,
  parameter int DAS_REPEAT      = DEF_DAS_REPEAT,
  parameter int CNT_W           = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 reset,
  input_conditioner_if.slave  io
);

  chan_state_t left_st;
  chan_state_t right_st;
  chan_state_t rotate_st;
  chan_state_t go_st;
  logic        left_tick;
  logic        right_tick;
  logic        rotate_tick;
  logic        go_tick;
  logic        conflict;
  logic        left_flag;
  logic        right_flag;
  logic        rotate_flag;

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DAS_DELAY(DAS_DELAY),
    .DAS_REPEAT(DAS_REPEAT), .CNT_W(CNT_W), .REPEAT_EN(1'b1)
  ) u_left (
    .clk(clk), .reset(reset), .raw(io.raw_left), .tick(left_tick), .state(left_st)
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DAS_DELAY(DAS_DELAY),
    .DAS_REPEAT(DAS_REPEAT), .CNT_W(CNT_W), .REPEAT_EN(1'b1)
  ) u_right (
    .clk(clk), .reset(reset), .raw(io.raw_right), .tick(right_tick), .state(right_st)
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DAS_DELAY(DAS_DELAY),
    .DAS_REPEAT(DAS_REPEAT), .CNT_W(CNT_W), .REPEAT_EN(1'b0)
  ) u_rotate (
    .clk(clk), .reset(reset), .raw(io.raw_rotate), .tick(rotate_tick), .state(rotate_st)
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DAS_DELAY(DAS_DELAY),
    .DAS_REPEAT(DAS_REPEAT), .CNT_W(CNT_W), .REPEAT_EN(1'b0)
  ) u_go (
    .clk(clk), .reset(reset), .raw(io.raw_go), .tick(go_tick), .state(go_st)
  );

  // Channels keep timing through a conflict; only their effect on the flags is masked.
  assign conflict = is_engaged(left_st) && is_engaged(right_st);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_flag   <= 1'b0;
      right_flag  <= 1'b0;
      rotate_flag <= 1'b0;
    end else begin
      if (conflict)          left_flag <= 1'b0;
      else if (left_tick)    left_flag <= 1'b1;
      else if (io.left_ack)  left_flag <= 1'b0;

      if (conflict)          right_flag <= 1'b0;
      else if (right_tick)   right_flag <= 1'b1;
      else if (io.right_ack) right_flag <= 1'b0;

      if (rotate_tick)        rotate_flag <= 1'b1;
      else if (io.rotate_ack) rotate_flag <= 1'b0;
    end
  end

  assign io.left   = left_flag;
  assign io.right  = right_flag;
  assign io.rotate = rotate_flag;
  assign io.go     = (go_st == ST_HELD) || (go_st == ST_RELEASE_DB);

  go_press_raises_go: assert property (@(posedge clk) disable iff (reset) go_tick |=> io.go);

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front end for the game controller's command inputs.
- Turns raw, bouncy push-button levels (left, right, rotate, go) into clean, debounced commands.
- left/right/rotate become sticky request flags that the controller consumes with an ack; left/right auto-repeat while held.
- Sits between the board-level KEY/SW pins (already inverted to active-high at top level) and the game control FSM.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz).
- DAS_DELAY, 8333333: held cycles after the accepted press before the first auto-repeat (~167 ms).
- DAS_REPEAT, 2500000: cycles between later auto-repeats (50 ms).
- CNT_W, 24: counter width; must hold max(DEBOUNCE_CYCLES, DAS_DELAY, DAS_REPEAT).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- raw_left  in  1  unsynchronised button level, 1 = pressed
- raw_right  in  1  unsynchronised button level
- raw_rotate  in  1  unsynchronised button level
- raw_go  in  1  unsynchronised button level
- left_ack  in  1  controller consumed the left request
- right_ack  in  1  controller consumed the right request
- rotate_ack  in  1  controller consumed the rotate request
- left  out  1  pending left-move request (sticky)
- right  out  1  pending right-move request (sticky)
- rotate  out  1  pending rotate request (sticky)
- go  out  1  debounced level of raw_go

Behaviour:
- Synchronisation:
  - Every raw input passes through a 2-flop synchroniser.
  - Debounce and request logic sees only the synchronised value.
  - Input-to-FSM latency: 2 cycles.
- Reset (async, active-high): all synchroniser flops, counters and FSMs go to 0/IDLE; left=right=rotate=go=0. Reset mid-press discards any pending request.
- Per-channel FSM (left, right, rotate, go), each with one CNT_W counter:
  - IDLE: sync=1 -> PRESS_DB, counter cleared.
  - PRESS_DB: sync=0 -> IDLE. Counter reaches DEBOUNCE_CYCLES-1 -> HELD, emit one press tick, counter cleared.
  - HELD: sync=0 -> RELEASE_DB. With repeat enabled, counter reaches DAS_DELAY-1 -> REPEAT, emit tick, counter cleared.
  - REPEAT: sync=0 -> RELEASE_DB. Counter reaches DAS_REPEAT-1 -> emit tick, counter cleared, stay in REPEAT.
  - RELEASE_DB: sync=1 -> back to the state it came from (HELD or REPEAT), counter cleared. Counter reaches DEBOUNCE_CYCLES-1 -> IDLE.
- Repeat enable: on for left and right; off for rotate and go.
- Counter saturation: counters never wrap; each is cleared on every state change.
- go output: 1 while the go channel is in HELD or RELEASE_DB, otherwise 0.
- Request flags (left/right/rotate):
  - Flag <= 1 on a channel tick.
  - Else flag <= 0 on ack.
  - Tick and ack in the same cycle: flag stays 1 (set wins).
  - Ack while flag=0 has no effect.
  - Ticks arriving while the flag is already 1 merge; there is no counting.
- Left/right conflict:
  - When both channels are in HELD/REPEAT/RELEASE_DB at once, their ticks are suppressed and both flags are cleared that cycle.
  - After one side releases, the other resumes its own timing without issuing a fresh press tick.
- Latency: from a clean raw press to the flag rising is 2 + DEBOUNCE_CYCLES cycles, ±1 registered.

Decomposition:
- Shared package holds:
  - the channel state encoding (IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB as 3-bit constants);
  - default timing constants for a 50 MHz clock;
  - reduced simulation timing constants.
- One sub-module, button_channel:
  - contains the synchroniser, debounce FSM, counter, auto-repeat and tick output;
  - has a REPEAT_EN parameter;
  - is instantiated four times.
- The top level holds the request flags, ack handling and left/right conflict logic.

Test Plan (DEBOUNCE_CYCLES=4, DAS_DELAY=10, DAS_REPEAT=3):
- raw_rotate 1 for 20 cycles, no ack -> rotate rises once, 6–7 cycles after the press edge, and stays 1; rotate_ack pulse -> 0 the next cycle; no further rises while held.
- raw_left toggles every cycle for 12 cycles, then stays 0 -> left never rises; channel back in IDLE.
- raw_right held 40 cycles, acking each request immediately -> first request ~6 cycles after press, second ~10 cycles later, then one every 3 cycles.
- raw_left held with flag pending; assert left_ack in the same cycle as a repeat tick -> left stays 1.
- raw_left held, then raw_right pressed -> once right passes debounce, both flags 0 and no ticks; release right -> left repeats resume within DAS_REPEAT cycles.
- raw_go held 10 cycles then released; reset pulsed mid-hold in a second run -> go=1 after ~6 cycles and 0 about 6 cycles after release; reset forces go, left, right and rotate to 0 immediately, independent of clk.
